// File: rtl/led_status_sched_pkg.sv
// led_pkg: shared constants and types for the LED status scheduler.
//   MODE_*   : 2-bit pattern codes carried per requester on the mode bus
//   state_t  : scheduler FSM state (IDLE = no grant, RUN = one requester owns LED)
//   LEVEL_W  : brightness width fed to the sigma-delta PWM
//   PHASE_W  : pattern phase counter width
//   pick_highest : one-hot of the highest set request bit (bit 3 wins)
package led_pkg;

    localparam int unsigned LEVEL_W = 6;
    localparam int unsigned PHASE_W = 7;
    localparam int unsigned N_REQ   = 4;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_SOLID   = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] pick_highest(input logic [N_REQ-1:0] r);
        logic [N_REQ-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (r[i]) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/led_status_sched_pwm_sd.sv
// led_pwm_sd: first-order sigma-delta PWM for the status LED.
//   clk, rst_n : clock, asynchronous active-low reset
//   level      : brightness 0..63
//   led_driver : registered carry of the accumulator; duty = level/64
module led_pwm_sd
    import led_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LEVEL_W-1:0] level,
    output logic               led_driver
);

    logic [LEVEL_W:0] acc;

    // Carry out of the previous sum is dropped before adding again, so the
    // MSB fires exactly level times per 64 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            led_driver <= 1'b0;
        end else begin
            acc        <= {1'b0, acc[LEVEL_W-1:0]} + {1'b0, level};
            led_driver <= acc[LEVEL_W];
        end
    end

endmodule

// File: rtl/led_status_sched.sv
// led_status_sched: priority-arbitrated LED status pattern scheduler.
//   TICK_DIV   : clk cycles per pattern tick (2..2^24)
//   clk, rst_n : clock, asynchronous active-low reset
//   req[3:0]   : status requesters, req[3] highest priority
//   mode[7:0]  : per-requester pattern code at mode[2i+1:2i]
//   grant[3:0] : one-hot owner of the LED, zero when idle
//   level[5:0] : registered brightness from the owner's pattern
//   led_driver : PWM drive output
module led_status_sched
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] mode,
    output logic [N_REQ-1:0]   grant,
    output logic [LEVEL_W-1:0] level,
    output logic               led_driver
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0]   div_cnt;
    logic               tick;
    state_t             state, state_n;
    logic [N_REQ-1:0]   grant_n;
    logic [N_REQ-1:0]   top_req;
    logic [PHASE_W-1:0] phase, phase_n;
    logic [1:0]         gmode;
    logic [LEVEL_W-1:0] level_n;

    // ---------------- tick divider ----------------
    assign tick = (div_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // ---------------- arbiter / FSM ----------------
    assign top_req = pick_highest(req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            phase <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            phase <= phase_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        phase_n = phase;
        unique case (state)
            IDLE: begin
                if (tick && (req != '0)) begin
                    state_n = RUN;
                    grant_n = top_req;
                    phase_n = '0;
                end
            end
            RUN: begin
                // Release is checked first so it wins over a coincident tick.
                if ((req & grant) == '0) begin
                    state_n = IDLE;
                    grant_n = '0;
                end else if (tick) begin
                    // Both one-hot: a numerically larger vector is a higher
                    // priority requester; equal means the owner stays.
                    if (top_req > grant) begin
                        grant_n = top_req;
                        phase_n = '0;
                    end else begin
                        phase_n = phase + PHASE_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    // ---------------- pattern generator ----------------
    always_comb begin
        gmode = MODE_OFF;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gmode = mode[2*i +: 2];
            end
        end
    end

    always_comb begin
        level_n = '0;
        unique case (gmode)
            MODE_OFF:     level_n = '0;
            MODE_SOLID:   level_n = '1;
            MODE_BLINK:   level_n = phase[5] ? '0 : '1;
            MODE_BREATHE: level_n = phase[6] ? ~phase[5:0] : phase[5:0];
            default:      level_n = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            level <= level_n;
        end
    end

    // ---------------- PWM ----------------
    led_pwm_sd u_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .level      (level),
        .led_driver (led_driver)
    );

endmodule
